// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data block RAM between the core memory
// stage and the UART loader/dumper, one access at a time with round-robin
// priority. Each access runs ISSUE -> RD_LAT WAIT cycles -> DONE (ack cycle).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1   // block RAM read latency in cycles, legal 1..4
) (
  input  logic              clk,
  input  logic              rst,
  // core memory stage
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  // UART loader/dumper
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  // block RAM pins
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // status
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;   // remaining WAIT cycles, 1 on the capture cycle
  logic       last;       // previous winner; the other side wins a tie
  logic       grant;      // IDLE edge that accepts a new access
  logic       pick;       // winner of this grant: 0 = core, 1 = loader
  logic       capture;    // last WAIT cycle: read data is on ram_rdata

  // State register; reset aborts any access in flight without an ack
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, winner selection and capture strobe
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (c_req || l_req) begin
          grant     = 1'b1;
          pick      = (c_req && l_req) ? ~last : l_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access datapath: latch winner's request, pulse enable, capture data, ack
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      c_ack     <= 1'b0;
      l_ack     <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
      gnt_id    <= 1'b0;
      last      <= 1'b1;
      wait_cnt  <= '0;
    end else begin
      // enable is high only in the ISSUE cycle; we/addr/wdata hold otherwise
      ram_en <= grant;
      c_ack  <= capture & ~gnt_id;
      l_ack  <= capture &  gnt_id;
      if (grant) begin
        last      <= pick;
        gnt_id    <= pick;
        ram_we    <= pick ? l_we    : c_we;
        ram_addr  <= pick ? l_addr  : c_addr;
        ram_wdata <= pick ? l_wdata : c_wdata;
      end
      if (state == ISSUE)     wait_cnt <= LAT_INIT;
      else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;
      // only reads update the winner's data register; the loser is untouched
      if (capture && !ram_we) begin
        if (gnt_id) l_rdata <= ram_rdata;
        else        c_rdata <= ram_rdata;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
